// File: rtl/wreg_hazard_pipe.sv
// Tracks the ID-selected destination register through ID/EX, EX/MEM and MEM/WB
// and derives the load-use stall and the EX operand forwarding selects.
module wreg_hazard_pipe #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_wreg,
  input  logic             id_regwrite,
  input  logic             id_load,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [REG_W-1:0] ex_wreg,
  output logic [REG_W-1:0] mem_wreg,
  output logic [REG_W-1:0] wb_wreg,
  output logic             wb_regwrite,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [REG_W-1:0] ex_rs, ex_rt;
  logic             ex_regwrite, ex_load, ex_valid;
  logic             mem_regwrite, mem_load, mem_valid;
  logic             wb_regwrite_q, wb_valid;

  logic             id_writes;
  logic             hit_rs, hit_rt;
  logic             bubble;

  // A write to $0 is never tracked, so a nonzero stage wreg is implied by regwrite.
  assign id_writes = id_regwrite & id_valid & (id_wreg != '0);

  assign hit_rs = id_use_rs & id_valid & (id_rs == ex_wreg);
  assign hit_rt = id_use_rt & id_valid & (id_rt == ex_wreg);
  assign stall  = ex_load & ex_regwrite & (hit_rs | hit_rt);
  assign bubble = stall | flush;

  assign wb_regwrite = wb_regwrite_q & wb_valid;

  always_comb begin
    fwd_a_sel = 2'b00;
    if (mem_regwrite && (mem_wreg == ex_rs))
      fwd_a_sel = 2'b01;
    else if (wb_regwrite && (wb_wreg == ex_rs))
      fwd_a_sel = 2'b10;
  end

  always_comb begin
    fwd_b_sel = 2'b00;
    if (mem_regwrite && (mem_wreg == ex_rt))
      fwd_b_sel = 2'b01;
    else if (wb_regwrite && (wb_wreg == ex_rt))
      fwd_b_sel = 2'b10;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_wreg       <= '0;
      ex_regwrite   <= 1'b0;
      ex_load       <= 1'b0;
      ex_valid      <= 1'b0;
      mem_wreg      <= '0;
      mem_regwrite  <= 1'b0;
      mem_load      <= 1'b0;
      mem_valid     <= 1'b0;
      wb_wreg       <= '0;
      wb_regwrite_q <= 1'b0;
      wb_valid      <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      mem_wreg      <= ex_wreg;
      mem_regwrite  <= ex_regwrite;
      mem_load      <= ex_load;
      mem_valid     <= ex_valid;
      wb_wreg       <= mem_wreg;
      wb_regwrite_q <= mem_regwrite;
      wb_valid      <= mem_valid;

      if (bubble) begin
        ex_rs       <= '0;
        ex_rt       <= '0;
        ex_wreg     <= '0;
        ex_regwrite <= 1'b0;
        ex_load     <= 1'b0;
        ex_valid    <= 1'b0;
      end else begin
        ex_rs       <= id_rs;
        ex_rt       <= id_rt;
        ex_wreg     <= id_wreg;
        ex_regwrite <= id_writes;
        ex_load     <= id_load & id_valid;
        ex_valid    <= id_valid;
      end

      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  // The load flag in MEM is kept for observability; no logic here consumes it.
  logic unused_mem_load;
  assign unused_mem_load = mem_load;

endmodule

// File: tb/tb_wreg_hazard_pipe.sv
// Directed and random stimulus for wreg_hazard_pipe, checked against a cycle
// model through an expected-result queue plus constant checks at key points.
module tb_wreg_hazard_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_wreg = '0;
  logic        id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic        id_regwrite = 1'b0, id_load = 1'b0, flush = 1'b0;
  logic        stall;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [4:0]  ex_wreg, mem_wreg, wb_wreg;
  logic        wb_regwrite;
  logic [31:0] stall_cnt;

  wreg_hazard_pipe #(.REG_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg),
    .id_regwrite(id_regwrite), .id_load(id_load), .flush(flush),
    .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .ex_wreg(ex_wreg), .mem_wreg(mem_wreg), .wb_wreg(wb_wreg),
    .wb_regwrite(wb_regwrite), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        stall;
    logic [1:0]  fa, fb;
    logic [4:0]  exw, memw, wbw;
    logic        wbrw;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  // Reference pipeline state
  logic [4:0]  m_ex_rs, m_ex_rt, m_ex_w, m_mem_w, m_wb_w;
  logic        m_ex_rw, m_ex_ld, m_ex_urs, m_ex_urt;
  logic        m_mem_rw, m_mem_ld, m_wb_rw;
  logic [31:0] m_cnt;

  task automatic model_clear();
    m_ex_rs = '0; m_ex_rt = '0; m_ex_w = '0; m_mem_w = '0; m_wb_w = '0;
    m_ex_rw = 0; m_ex_ld = 0; m_ex_urs = 0; m_ex_urt = 0;
    m_mem_rw = 0; m_mem_ld = 0; m_wb_rw = 0; m_cnt = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] w,
                        input logic rw, input logic ld, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wreg = w; id_regwrite = rw; id_load = ld; flush = fl;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock: push model expectation, compare on the falling edge, advance model.
  task automatic tick();
    exp_t e;
    exp_t g;
    logic bad_load_fwd;
    e.stall = m_ex_ld && m_ex_rw && id_valid &&
              ((id_use_rs && id_rs == m_ex_w) || (id_use_rt && id_rt == m_ex_w));
    e.fa = (m_mem_rw && m_mem_w == m_ex_rs) ? 2'b01 :
           (m_wb_rw && m_wb_w == m_ex_rs) ? 2'b10 : 2'b00;
    e.fb = (m_mem_rw && m_mem_w == m_ex_rt) ? 2'b01 :
           (m_wb_rw && m_wb_w == m_ex_rt) ? 2'b10 : 2'b00;
    e.exw = m_ex_w; e.memw = m_mem_w; e.wbw = m_wb_w; e.wbrw = m_wb_rw; e.cnt = m_cnt;
    sb.push_back(e);

    @(negedge clk);
    g = sb.pop_front();
    chk("stall", 32'(stall), 32'(g.stall));
    chk("fwd_a_sel", 32'(fwd_a_sel), 32'(g.fa));
    chk("fwd_b_sel", 32'(fwd_b_sel), 32'(g.fb));
    chk("ex_wreg", 32'(ex_wreg), 32'(g.exw));
    chk("mem_wreg", 32'(mem_wreg), 32'(g.memw));
    chk("wb_wreg", 32'(wb_wreg), 32'(g.wbw));
    chk("wb_regwrite", 32'(wb_regwrite), 32'(g.wbrw));
    chk("stall_cnt", stall_cnt, g.cnt);
    // A load sitting in MEM must never be the forwarding source for a used EX operand.
    bad_load_fwd = (fwd_a_sel == 2'b01 && m_mem_ld && m_ex_urs) ||
                   (fwd_b_sel == 2'b01 && m_mem_ld && m_ex_urt);
    chk("load_fwd_from_mem", 32'(bad_load_fwd), 32'd0);

    @(posedge clk);
    m_wb_w = m_mem_w; m_wb_rw = m_mem_rw;
    m_mem_w = m_ex_w; m_mem_rw = m_ex_rw; m_mem_ld = m_ex_ld;
    if (e.stall || flush) begin
      m_ex_rs = '0; m_ex_rt = '0; m_ex_w = '0;
      m_ex_rw = 0; m_ex_ld = 0; m_ex_urs = 0; m_ex_urt = 0;
    end else begin
      m_ex_rs = id_rs; m_ex_rt = id_rt; m_ex_w = id_wreg;
      m_ex_rw = id_regwrite && id_valid && (id_wreg != 5'd0);
      m_ex_ld = id_load && id_valid;
      m_ex_urs = id_use_rs && id_valid;
      m_ex_urt = id_use_rt && id_valid;
    end
    if (e.stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall), 0);
    chk({tag, "_fwd_a"}, 32'(fwd_a_sel), 0);
    chk({tag, "_fwd_b"}, 32'(fwd_b_sel), 0);
    chk({tag, "_ex_wreg"}, 32'(ex_wreg), 0);
    chk({tag, "_mem_wreg"}, 32'(mem_wreg), 0);
    chk({tag, "_wb_wreg"}, 32'(wb_wreg), 0);
    chk({tag, "_wb_regwrite"}, 32'(wb_regwrite), 0);
    chk({tag, "_stall_cnt"}, stall_cnt, 0);
  endtask

  initial begin
    model_clear();
    #12;
    chk_all_zero("reset");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // ALU back-to-back and distance-2 forwarding
    set_id(1, 1, 2, 1, 1, 3, 1, 0, 0); tick();
    set_id(1, 3, 2, 1, 1, 8, 1, 0, 0); tick();
    chk("alu_fwd_a_mem", 32'(fwd_a_sel), 32'd1);
    set_id(1, 1, 3, 1, 1, 9, 1, 0, 0); tick();
    chk("alu_fwd_b_wb", 32'(fwd_b_sel), 32'd2);

    // Two producers of $4: nearer one wins for both operands
    set_id(1, 1, 2, 1, 1, 4, 1, 0, 0); tick();
    set_id(1, 1, 2, 1, 1, 4, 1, 0, 0); tick();
    set_id(1, 4, 4, 1, 1, 10, 1, 0, 0); tick();
    chk("prio_fwd_a", 32'(fwd_a_sel), 32'd1);
    chk("prio_fwd_b", 32'(fwd_b_sel), 32'd1);

    // Load-use: one bubble, then WB forward
    set_id(1, 1, 2, 1, 0, 5, 1, 1, 0); tick();
    set_id(1, 5, 2, 1, 1, 11, 1, 0, 0); #1;
    chk("lu_stall_on", 32'(stall), 32'd1);
    tick();
    chk("lu_bubble_ex", 32'(ex_wreg), 32'd0);
    chk("lu_load_mem", 32'(mem_wreg), 32'd5);
    #1;
    chk("lu_stall_off", 32'(stall), 32'd0);
    tick();
    chk("lu_fwd_a_wb", 32'(fwd_a_sel), 32'd2);
    chk("lu_stall_cnt", stall_cnt, 32'd1);

    // $0 destination is never forwarded; unused source never stalls
    set_id(1, 1, 2, 1, 1, 0, 1, 0, 0); tick();
    set_id(1, 0, 2, 1, 1, 12, 1, 0, 0); #1;
    chk("zero_stall", 32'(stall), 32'd0);
    tick();
    chk("zero_fwd_a", 32'(fwd_a_sel), 32'd0);
    set_id(1, 1, 2, 1, 0, 6, 1, 1, 0); tick();
    set_id(1, 1, 6, 1, 0, 13, 1, 0, 0); #1;
    chk("unused_rt_stall", 32'(stall), 32'd0);
    tick();

    // Flush during the stall cycle: single bubble, flushed write never reaches WB
    set_id(1, 1, 2, 1, 0, 7, 1, 1, 0); tick();
    set_id(1, 7, 2, 1, 1, 14, 1, 0, 1); #1;
    chk("flush_stall_on", 32'(stall), 32'd1);
    tick();
    chk("flush_bubble_ex", 32'(ex_wreg), 32'd0);
    chk("flush_stall_cnt", stall_cnt, 32'd2);
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("flush_no_wb", 32'(wb_regwrite && wb_wreg == 5'd14), 32'd0);
    end

    // Random traffic over a small register range to provoke hazards
    for (int i = 0; i < 60; i++) begin
      set_id(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 9) == 0));
      tick();
    end

    // Asynchronous reset with three writers in flight
    set_id(1, 1, 2, 1, 1, 15, 1, 0, 0); tick();
    set_id(1, 1, 2, 1, 1, 16, 1, 0, 0); tick();
    set_id(1, 1, 2, 1, 1, 17, 1, 0, 0); tick();
    chk("pre_reset_wb_regwrite", 32'(wb_regwrite), 32'd1);
    idle();
    #2 reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    model_clear();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_reset_no_wb", 32'(wb_regwrite), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
